ma_crossover_detector: RTL and testbench

//  Consumes raw offset-binary samples drained from the incoming data FIFO.

---
 rtl/alg_pkg.sv | 27 ++
 rtl/ma_window.sv | 56 +++++
 rtl/ma_crossover_detector.sv | 174 +++++++++++++++++
 tb/tb_ma_crossover_detector.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alg_pkg.sv
// Shared definitions for the moving-average crossover detector.
// Holds the default parameter values, the FSM state type and the helper that
// sizes each window's running sum so it can never overflow.
package alg_pkg;

  localparam int DATA_WIDTH  = 11;
  localparam int CTR_WIDTH   = 22;
  localparam int N_SHORT     = 16;
  localparam int N_LONG      = 32;
  localparam int DATA_OFFSET = 1024;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } xdet_state_t;

  // A sum of n values of data_w bits needs data_w + log2(n) bits (n a power of 2).
  function automatic int sum_width(input int data_w, input int n);
    return data_w + $clog2(n);
  endfunction

  localparam int SUM_S_W = sum_width(DATA_WIDTH, N_SHORT);
  localparam int SUM_L_W = sum_width(DATA_WIDTH, N_LONG);
  localparam int MA_W    = DATA_WIDTH;

endpackage

// File: rtl/ma_window.sv
// Fixed-length moving-average window.
// Keeps the last N samples in a circular buffer plus a running sum; every shift
// replaces the oldest entry and adjusts the sum by (new - oldest). The buffer
// starts cleared, so the sum is exact while the window is still filling.
// Ports:
//   clk, rst  clock, asynchronous active-high reset
//   clr       synchronous flush of buffer, pointer and sum
//   shift_en  push x into the window this cycle
//   x         new sample (unsigned, W bits)
//   avg       sum / N, truncated (W bits), reflects all samples pushed so far
module ma_window
  import alg_pkg::*;
#(
  parameter int N = 16,
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         shift_en,
  input  logic [W-1:0] x,
  output logic [W-1:0] avg
);

  localparam int LOG2N = $clog2(N);
  localparam int SW    = sum_width(W, N);

  logic [W-1:0]     win_q [N];
  logic [LOG2N-1:0] ptr_q;
  logic [SW-1:0]    sum_q;
  logic [SW-1:0]    sum_d;

  // The oldest entry sits at ptr_q; it leaves the sum as x enters.
  always_comb begin
    sum_d = sum_q + SW'(x) - SW'(win_q[ptr_q]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
      sum_q <= '0;
      for (int i = 0; i < N; i++) win_q[i] <= '0;
    end else if (clr) begin
      ptr_q <= '0;
      sum_q <= '0;
      for (int i = 0; i < N; i++) win_q[i] <= '0;
    end else if (shift_en) begin
      win_q[ptr_q] <= x;
      ptr_q        <= ptr_q + LOG2N'(1);
      sum_q        <= sum_d;
    end
  end

  assign avg = W'(sum_q >> LOG2N);

endmodule

// File: rtl/ma_crossover_detector.sv
// Moving-average crossover detector.
// Rectifies offset-binary samples about the zero centreline, tracks a short
// and a long moving average and raises a timestamped event whenever the short
// average crosses the long one. One sample is taken at most every other cycle
// and nothing is taken while an event waits for its consumer, so events are
// never lost or overwritten.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   clr               synchronous soft clear (windows, counters, FSM)
//   in_valid/in_ready sample handshake; in_data is offset binary
//   ma_valid          one-cycle pulse when ma_short/ma_long have updated
//   ma_short/ma_long  truncated short/long averages
//   ev_valid/ev_ready event handshake; ev_* held until accepted
//   ev_rise           1 = short rose above long, 0 = short fell to <= long
//   ev_index          index of the sample that caused the event
module ma_crossover_detector
  import alg_pkg::*;
#(
  parameter int DATA_W = DATA_WIDTH,
  parameter int CTR_W  = CTR_WIDTH,
  parameter int N_S    = N_SHORT,
  parameter int N_L    = N_LONG,
  parameter int OFFSET = DATA_OFFSET
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              ma_valid,
  output logic [DATA_W-1:0] ma_short,
  output logic [DATA_W-1:0] ma_long,
  output logic              ev_valid,
  input  logic              ev_ready,
  output logic              ev_rise,
  output logic [CTR_W-1:0]  ev_index
);

  localparam int FILL_W = $clog2(N_L);

  // |s - OFFSET| computed as a signed difference, then folded to magnitude.
  function automatic logic [DATA_W-1:0] rectify(input logic [DATA_W-1:0] s);
    logic signed [DATA_W:0] d;
    d = $signed({1'b0, s}) - $signed((DATA_W + 1)'(OFFSET));
    return d[DATA_W] ? DATA_W'(-d) : d[DATA_W-1:0];
  endfunction

  xdet_state_t       state_q, state_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [CTR_W-1:0]  idx_q, idx_d;
  logic [CTR_W-1:0]  tag_q, tag_d;
  logic              prev_gt_q, prev_gt_d;
  logic              ma_valid_q, ma_valid_d;
  logic              ev_valid_q, ev_valid_d;
  logic              ev_rise_q, ev_rise_d;
  logic [CTR_W-1:0]  ev_index_q, ev_index_d;

  logic              accept;
  logic              gt;
  logic [DATA_W-1:0] x_rect;

  // Blocking on ma_valid limits intake to one sample per two cycles and gives
  // the compare stage a cycle in which no new sample can disturb it.
  assign in_ready = !rst && !clr && !ev_valid_q && !ma_valid_q;
  assign accept   = in_valid && in_ready;
  assign x_rect   = rectify(in_data);

  ma_window #(.N(N_S), .W(DATA_W)) u_win_short (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .shift_en (accept),
    .x        (x_rect),
    .avg      (ma_short)
  );

  ma_window #(.N(N_L), .W(DATA_W)) u_win_long (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .shift_en (accept),
    .x        (x_rect),
    .avg      (ma_long)
  );

  // Equality counts as "not above", so a tie after a rise is a falling event.
  assign gt = (ma_short > ma_long);

  always_comb begin
    state_d    = state_q;
    fill_d     = fill_q;
    idx_d      = idx_q;
    tag_d      = tag_q;
    prev_gt_d  = prev_gt_q;
    ma_valid_d = 1'b0;
    ev_valid_d = ev_valid_q;
    ev_rise_d  = ev_rise_q;
    ev_index_d = ev_index_q;

    if (clr) begin
      state_d    = FILL;
      fill_d     = '0;
      idx_d      = '0;
      tag_d      = '0;
      prev_gt_d  = 1'b0;
      ev_valid_d = 1'b0;
      ev_rise_d  = 1'b0;
      ev_index_d = '0;
    end else begin
      // Sample edge: tag the sample with the current index, then advance.
      if (accept) begin
        ma_valid_d = 1'b1;
        tag_d      = idx_q;
        idx_d      = idx_q + CTR_W'(1);
        if (state_q == FILL) begin
          fill_d = fill_q + FILL_W'(1);
          if (fill_q == FILL_W'(N_L - 1)) state_d = PRIME;
        end
      end

      // Compare edge: the averages of the tagged sample are now on ma_*.
      if (ma_valid_q) begin
        case (state_q)
          PRIME: begin
            prev_gt_d = gt;
            state_d   = RUN;
          end
          RUN: begin
            if (gt != prev_gt_q) begin
              ev_valid_d = 1'b1;
              ev_rise_d  = gt;
              ev_index_d = tag_q;
              prev_gt_d  = gt;
            end
          end
          default: ;
        endcase
      end

      if (ev_valid_q && ev_ready) ev_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= FILL;
      fill_q     <= '0;
      idx_q      <= '0;
      tag_q      <= '0;
      prev_gt_q  <= 1'b0;
      ma_valid_q <= 1'b0;
      ev_valid_q <= 1'b0;
      ev_rise_q  <= 1'b0;
      ev_index_q <= '0;
    end else begin
      state_q    <= state_d;
      fill_q     <= fill_d;
      idx_q      <= idx_d;
      tag_q      <= tag_d;
      prev_gt_q  <= prev_gt_d;
      ma_valid_q <= ma_valid_d;
      ev_valid_q <= ev_valid_d;
      ev_rise_q  <= ev_rise_d;
      ev_index_q <= ev_index_d;
    end
  end

  assign ma_valid = ma_valid_q;
  assign ev_valid = ev_valid_q;
  assign ev_rise  = ev_rise_q;
  assign ev_index = ev_index_q;

endmodule

// File: tb/tb_ma_crossover_detector.sv
// Bench for ma_crossover_detector: a default instance and a CTR_W=6 instance
// (index wrap), driven one at a time through a shared stimulus path. A
// history-based model computes each average as the plain mean of the last N
// rectified samples and derives the expected event list from it.
module tb_ma_crossover_detector;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, clr, in_valid, ev_ready, sel;
  logic [10:0] in_data;

  logic        in_ready0, ma_valid0, ev_valid0, ev_rise0;
  logic [10:0] ma_short0, ma_long0;
  logic [21:0] ev_index0;
  logic        in_ready6, ma_valid6, ev_valid6, ev_rise6;
  logic [10:0] ma_short6, ma_long6;
  logic [5:0]  ev_index6;
  logic        in_valid0, in_valid6;

  assign in_valid0 = in_valid && !sel;
  assign in_valid6 = in_valid && sel;

  ma_crossover_detector dut0 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid0), .in_ready(in_ready0),
    .in_data(in_data), .ma_valid(ma_valid0), .ma_short(ma_short0), .ma_long(ma_long0),
    .ev_valid(ev_valid0), .ev_ready(ev_ready), .ev_rise(ev_rise0), .ev_index(ev_index0)
  );

  ma_crossover_detector #(.CTR_W(6)) dut6 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid6), .in_ready(in_ready6),
    .in_data(in_data), .ma_valid(ma_valid6), .ma_short(ma_short6), .ma_long(ma_long6),
    .ev_valid(ev_valid6), .ev_ready(ev_ready), .ev_rise(ev_rise6), .ev_index(ev_index6)
  );

  logic        c_in_ready, c_ma_valid, c_ev_valid, c_ev_rise;
  logic [10:0] c_ma_short, c_ma_long;
  logic [21:0] c_ev_index;
  assign c_in_ready = sel ? in_ready6  : in_ready0;
  assign c_ma_valid = sel ? ma_valid6  : ma_valid0;
  assign c_ev_valid = sel ? ev_valid6  : ev_valid0;
  assign c_ev_rise  = sel ? ev_rise6   : ev_rise0;
  assign c_ma_short = sel ? ma_short6  : ma_short0;
  assign c_ma_long  = sel ? ma_long6   : ma_long0;
  assign c_ev_index = sel ? {16'd0, ev_index6} : ev_index0;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { int s; int l; } ma_t;
  typedef struct { bit rise; int idx; } ev_t;

  int  mhist[$];
  ma_t exp_ma[$];
  ev_t exp_ev[$];
  int  midx, mcnt, ctrw;
  bit  mprev_gt;

  function automatic int win_avg(input int n);
    int s = 0;
    int sz = mhist.size();
    for (int i = 0; i < n; i++) if (sz - 1 - i >= 0) s += mhist[sz - 1 - i];
    return s / n;
  endfunction

  task automatic model_reset(input int w);
    mhist.delete();
    exp_ma.delete();
    exp_ev.delete();
    midx = 0; mcnt = 0; mprev_gt = 1'b0; ctrw = w;
  endtask

  task automatic model_accept(input int code);
    int x, s, l;
    bit gt;
    x = (code >= 1024) ? code - 1024 : 1024 - code;
    mhist.push_back(x);
    s = win_avg(16);
    l = win_avg(32);
    exp_ma.push_back('{s: s, l: l});
    mcnt++;
    gt = (s > l);
    if (mcnt == 32) mprev_gt = gt;
    else if (mcnt > 32 && gt != mprev_gt) begin
      exp_ev.push_back('{rise: gt, idx: midx % (1 << ctrw)});
      mprev_gt = gt;
    end
    midx++;
  endtask

  // ---------------- compare process ----------------
  int n_events = 0;
  int last_s, last_l, cap_s, cap_l, cap_idx, cap_rise;
  bit evp, evrp, prise;
  int pidx;

  always @(negedge clk) begin
    if (rst) begin
      evp = 1'b0; evrp = 1'b1;
    end else begin
      if (c_ma_valid) begin
        if (exp_ma.size() == 0) fail_now("ma_valid_unexpected");
        else begin
          ma_t e;
          e = exp_ma.pop_front();
          check("ma_short", int'(c_ma_short), e.s);
          check("ma_long", int'(c_ma_long), e.l);
        end
        last_s = int'(c_ma_short);
        last_l = int'(c_ma_long);
      end
      if (c_ev_valid) check("in_ready_while_ev", int'(c_in_ready), 0);
      if (c_ev_valid && !evp) begin
        n_events++;
        cap_s = last_s; cap_l = last_l;
        cap_rise = int'(c_ev_rise); cap_idx = int'(c_ev_index);
        if (exp_ev.size() == 0) fail_now("ev_valid_unexpected");
        else begin
          ev_t e;
          e = exp_ev.pop_front();
          check("ev_rise", int'(c_ev_rise), int'(e.rise));
          check("ev_index", int'(c_ev_index), e.idx);
        end
      end
      if (c_ev_valid && evp && !evrp) begin
        check("ev_rise_stable", int'(c_ev_rise), int'(prise));
        check("ev_index_stable", int'(c_ev_index), pidx);
      end
      evp = c_ev_valid; evrp = ev_ready; prise = c_ev_rise; pidx = int'(c_ev_index);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input int code);
    int n = 0;
    in_valid = 1'b1;
    in_data  = 11'(code);
    while (!c_in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!c_in_ready) begin
      fail_now("accept_timeout");
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    model_accept(code);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_n(input int code, input int n);
    for (int i = 0; i < n; i++) send(code);
  endtask

  task automatic settle();
    repeat (4) @(negedge clk);
    check("ma_queue_drained", exp_ma.size(), 0);
    check("ev_queue_drained", exp_ev.size(), 0);
  endtask

  task automatic check_reset_outputs();
    check("rst_in_ready", int'(c_in_ready), 1);
    check("rst_ma_valid", int'(c_ma_valid), 0);
    check("rst_ma_short", int'(c_ma_short), 0);
    check("rst_ma_long", int'(c_ma_long), 0);
    check("rst_ev_valid", int'(c_ev_valid), 0);
    check("rst_ev_rise", int'(c_ev_rise), 0);
    check("rst_ev_index", int'(c_ev_index), 0);
  endtask

  task automatic do_reset(input bit s);
    @(negedge clk);
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; sel = s;
    model_reset(s ? 6 : 22);
    #1 check("in_ready_during_rst", int'(c_in_ready), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n_events = 0;
    #1 check_reset_outputs();
  endtask

  task automatic check_ev(input string name, input int cnt, input int rise, input int idx,
                          input int s, input int l);
    check({name, "_count"}, n_events, cnt);
    check({name, "_rise"}, cap_rise, rise);
    check({name, "_index"}, cap_idx, idx);
    check({name, "_short"}, cap_s, s);
    check({name, "_long"}, cap_l, l);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_data = '0; ev_ready = 1'b1; sel = 1'b0;

    // 1: fill with centreline samples
    do_reset(1'b0);
    send_n(1024, 32);
    settle();
    check("s1_events", n_events, 0);
    check("s1_ma_short", last_s, 0);
    check("s1_ma_long", last_l, 0);

    // 2: positive step -> rising event on the first step sample
    send(1124);
    settle();
    check_ev("s2", 1, 1, 32, 6, 3);

    // 3: hold the step until the long average catches up (tie -> falling)
    send_n(1124, 31);
    settle();
    check_ev("s3", 2, 0, 63, 100, 100);

    // 4: negative step after an async reset mid-stream gives the same events
    do_reset(1'b0);
    send_n(1024, 32);
    send(924);
    settle();
    check_ev("s4r", 1, 1, 32, 6, 3);
    send_n(924, 31);
    settle();
    check_ev("s4f", 2, 0, 63, 100, 100);

    // 5: consumer stalls for 10 cycles with a sample waiting
    ev_ready = 1'b0;
    send(1224);
    begin
      int n = 0;
      while (!c_ev_valid && n < 5) begin
        @(negedge clk);
        n++;
      end
    end
    check("s5_ev_valid_seen", int'(c_ev_valid), 1);
    in_valid = 1'b1;
    in_data  = 11'd1124;
    repeat (10) begin
      @(negedge clk);
      check("s5_ev_held", int'(c_ev_valid), 1);
    end
    ev_ready = 1'b1;
    @(negedge clk);
    check("s5_ev_cleared", int'(c_ev_valid), 0);
    check("s5_in_ready_back", int'(c_in_ready), 1);
    send(1124);
    settle();
    check_ev("s5", 3, 1, 64, 106, 103);

    // 6: narrow index counter wraps; then clear mid-stream
    do_reset(1'b1);
    send_n(1024, 70);
    send(1124);
    settle();
    check_ev("s6r", 1, 1, 6, 6, 3);
    send_n(1124, 31);
    settle();
    check_ev("s6f", 2, 0, 37, 100, 100);

    send_n(1124, 5);
    settle();
    @(negedge clk);
    clr = 1'b1; in_valid = 1'b1; in_data = 11'd1124;
    model_reset(6);
    #1 check("clr_in_ready", int'(c_in_ready), 0);
    @(negedge clk);
    clr = 1'b0; in_valid = 1'b0;
    n_events = 0;
    #1 check_reset_outputs();
    send_n(1024, 16);
    send_n(1124, 16);
    settle();
    check("s6_clr_fill_events", n_events, 0);
    send_n(1124, 16);
    settle();
    check_ev("s6c", 1, 0, 47, 100, 100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
